// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Baud-rate tick generator for the UART datapath. A prescale counter divides
// the system clock by a run-time programmable divisor to produce the oversample
// tick. An oversample phase counter then derives the mid-bit and end-of-bit
// ticks from it. The receiver can restart the bit phase on a detected start
// edge using sync_clr.
//
// Parameters
//   DIV_W       width of the divisor register and prescale counter
//   DEFAULT_DIV divisor loaded at reset
//   OVERSAMPLE  oversample ticks per bit (power of two, >= 4)
//
// Ports
//   clk       in   system clock, rising-edge active
//   reset_n   in   asynchronous active-low reset
//   en        in   count enable; low freezes cnt and phase
//   div_load  in   strobe: capture div_in as the new divisor (needs div_in >= 2)
//   div_in    in   new divisor, in clk cycles per oversample tick
//   sync_clr  in   strobe: restart the bit phase from zero
//   os_tick   out  one-cycle pulse every div_cur enabled cycles
//   mid_tick  out  one-cycle pulse at the middle of each bit
//   bit_tick  out  one-cycle pulse at the end of each bit
//   phase     out  current oversample index within the bit
//   div_cur   out  divisor currently in use
//   load_err  out  one-cycle pulse when a div_load is rejected

module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 27,
  parameter int OVERSAMPLE  = 16,
  localparam int PH_W       = $clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             sync_clr,
  output logic             os_tick,
  output logic             mid_tick,
  output logic             bit_tick,
  output logic [PH_W-1:0]  phase,
  output logic [DIV_W-1:0] div_cur,
  output logic             load_err
);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic             prescale_wrap;
  logic             load_ok;
  logic             load_bad;

  // A divisor below 2 would make the prescaler degenerate, so such loads are
  // refused and only flagged.
  assign prescale_wrap = (cnt == (div_reg - DIV_W'(1)));
  assign load_ok       = div_load && (div_in > DIV_W'(1));
  assign load_bad      = div_load && !(div_in > DIV_W'(1));
  assign div_cur       = div_reg;

  // Ticks default low every edge so each one is a single-cycle pulse. An
  // accepted load outranks sync_clr; both clear the counters, so a load
  // always starts a clean period with the new divisor. The phase counter
  // wraps naturally because OVERSAMPLE is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg  <= DIV_RESET;
      cnt      <= '0;
      phase    <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      load_err <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      load_err <= load_bad;
      if (load_ok) begin
        div_reg <= div_in;
        cnt     <= '0;
        phase   <= '0;
      end else if (sync_clr) begin
        cnt     <= '0;
        phase   <= '0;
      end else if (en) begin
        if (prescale_wrap) begin
          cnt      <= '0;
          os_tick  <= 1'b1;
          phase    <= phase + PH_W'(1);
          mid_tick <= (phase == PH_MID);
          bit_tick <= (phase == PH_LAST);
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen
// Directed self-checking bench for baud_tick_gen with the default parameters
// (divisor 27, 16x oversample). Single-edge strobe cases come from a vector
// table; long tick cadences are checked by runEdges against a small phase
// model with hand-computed first-tick edge numbers.

module tb_baud_tick_gen;

  localparam int DIV_W = 16;
  localparam int OS    = 16;

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] div_in;
  logic             sync_clr;
  logic             os_tick;
  logic             mid_tick;
  logic             bit_tick;
  logic [3:0]       phase;
  logic [DIV_W-1:0] div_cur;
  logic             load_err;

  int checks = 0;
  int errors = 0;

  // Statistics gathered by runEdges
  int osCount, midCount, bitCount;
  int firstOs, firstMid, firstBit;
  int badCount;

  typedef struct {
    logic             en;
    logic             load;
    logic [DIV_W-1:0] divIn;
    logic             sync;
    logic             expOs;
    logic             expMid;
    logic             expBit;
    logic [3:0]       expPhase;
    logic [DIV_W-1:0] expDiv;
    logic             expErr;
  } vec_t;

  vec_t vecs [10];

  baud_tick_gen #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(27),
    .OVERSAMPLE (OS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .div_load(div_load),
    .div_in  (div_in),
    .sync_clr(sync_clr),
    .os_tick (os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .phase   (phase),
    .div_cur (div_cur),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one table row for a single edge, then compare all outputs
  task automatic applyStimulus(input int idx);
    en       = vecs[idx].en;
    div_load = vecs[idx].load;
    div_in   = vecs[idx].divIn;
    sync_clr = vecs[idx].sync;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d os_tick", idx), int'(os_tick), int'(vecs[idx].expOs));
    checkOutput($sformatf("vec%0d mid_tick", idx), int'(mid_tick), int'(vecs[idx].expMid));
    checkOutput($sformatf("vec%0d bit_tick", idx), int'(bit_tick), int'(vecs[idx].expBit));
    checkOutput($sformatf("vec%0d phase", idx), int'(phase), int'(vecs[idx].expPhase));
    checkOutput($sformatf("vec%0d div_cur", idx), int'(div_cur), int'(vecs[idx].expDiv));
    checkOutput($sformatf("vec%0d load_err", idx), int'(load_err), int'(vecs[idx].expErr));
    div_load = 1'b0;
    sync_clr = 1'b0;
    div_in   = '0;
  endtask

  // Run n edges with strobes idle, tracking tick counts, first-tick edge
  // numbers, tick periods and the expected phase/mid/bit behaviour.
  task automatic runEdges(input int n, input int expDiv, input int startPhase);
    int expPhase;
    int lastOs, lastMid, lastBit;
    logic expMid, expBit;
    expPhase = startPhase;
    lastOs = 0; lastMid = 0; lastBit = 0;
    osCount = 0; midCount = 0; bitCount = 0;
    firstOs = -1; firstMid = -1; firstBit = -1;
    badCount = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      expMid = 1'b0;
      expBit = 1'b0;
      if (os_tick) begin
        expMid   = (expPhase == OS / 2 - 1);
        expBit   = (expPhase == OS - 1);
        expPhase = (expPhase + 1) % OS;
        osCount++;
        if (firstOs < 0) firstOs = i;
        if (lastOs > 0 && (i - lastOs) != expDiv) badCount++;
        lastOs = i;
      end
      if (mid_tick) begin
        midCount++;
        if (firstMid < 0) firstMid = i;
        if (lastMid > 0 && (i - lastMid) != expDiv * OS) badCount++;
        lastMid = i;
      end
      if (bit_tick) begin
        bitCount++;
        if (firstBit < 0) firstBit = i;
        if (lastBit > 0 && (i - lastBit) != expDiv * OS) badCount++;
        lastBit = i;
      end
      if (mid_tick != expMid) badCount++;
      if (bit_tick != expBit) badCount++;
      if (int'(phase) != expPhase) badCount++;
    end
  endtask

  initial begin
    //            en    load  divIn  sync  os    mid   bit   ph    div  err
    vecs[0] = '{1'b1, 1'b1, 16'd1,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd27, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd27, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd27, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 16'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd5,  1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'd27, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd27, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd27, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'd9,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd9,  1'b0};
    vecs[7] = '{1'b1, 1'b1, 16'd1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd9,  1'b1};
    vecs[8] = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd9,  1'b0};
    vecs[9] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd9,  1'b0};

    reset_n  = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    sync_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset os_tick", int'(os_tick), 0);
    checkOutput("reset mid_tick", int'(mid_tick), 0);
    checkOutput("reset bit_tick", int'(bit_tick), 0);
    checkOutput("reset phase", int'(phase), 0);
    checkOutput("reset div_cur", int'(div_cur), 27);
    checkOutput("reset load_err", int'(load_err), 0);

    // Default cadence from reset release
    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b1;
    runEdges(432, 27, 0);
    checkOutput("default first os", firstOs, 27);
    checkOutput("default first mid", firstMid, 216);
    checkOutput("default first bit", firstBit, 432);
    checkOutput("default os count", osCount, 16);
    checkOutput("default model", badCount, 0);

    // Rejected loads (cnt=5 when the first arrives)
    runEdges(5, 27, 0);
    for (int i = 0; i <= 2; i++) applyStimulus(i);
    runEdges(432, 27, 0);
    checkOutput("invalid first os", firstOs, 19);
    checkOutput("invalid first mid", firstMid, 208);
    checkOutput("invalid first bit", firstBit, 424);
    checkOutput("invalid model", badCount, 0);

    // Runtime load of divisor 5 mid-period (cnt=8)
    applyStimulus(3);
    runEdges(160, 5, 0);
    checkOutput("load5 first os", firstOs, 5);
    checkOutput("load5 first mid", firstMid, 40);
    checkOutput("load5 first bit", firstBit, 80);
    checkOutput("load5 bit count", bitCount, 2);
    checkOutput("load5 model", badCount, 0);

    // Back to 27, then resync at cnt=26 where an os_tick was due
    applyStimulus(4);
    runEdges(107, 27, 0);
    checkOutput("pre-sync os count", osCount, 3);
    applyStimulus(5);
    runEdges(432, 27, 0);
    checkOutput("sync first os", firstOs, 27);
    checkOutput("sync first mid", firstMid, 216);
    checkOutput("sync first bit", firstBit, 432);
    checkOutput("sync model", badCount, 0);

    // Enable gating at cnt=10, phase=3
    runEdges(91, 27, 0);
    checkOutput("gate start phase", int'(phase), 3);
    en = 1'b0;
    runEdges(100, 27, 3);
    checkOutput("gate idle os count", osCount, 0);
    checkOutput("gate idle phase", int'(phase), 3);
    checkOutput("gate idle model", badCount, 0);
    en = 1'b1;
    runEdges(130, 27, 3);
    checkOutput("gate resume first os", firstOs, 17);
    checkOutput("gate resume first mid", firstMid, 125);
    checkOutput("gate resume model", badCount, 0);

    // Accepted load together with sync_clr
    applyStimulus(6);
    runEdges(144, 9, 0);
    checkOutput("collide first os", firstOs, 9);
    checkOutput("collide first bit", firstBit, 144);
    checkOutput("collide model", badCount, 0);

    // Rejected load together with sync_clr at phase 2
    runEdges(20, 9, 0);
    checkOutput("pre-reject phase", int'(phase), 2);
    applyStimulus(7);
    applyStimulus(8);

    // en low on the edge where an os_tick was due (cnt=8)
    runEdges(7, 9, 0);
    applyStimulus(9);
    en = 1'b1;
    runEdges(46, 9, 0);
    checkOutput("en hold first os", firstOs, 1);
    checkOutput("en hold os count", osCount, 6);
    checkOutput("en hold model", badCount, 0);
    checkOutput("pre-reset os_tick", int'(os_tick), 1);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async os_tick", int'(os_tick), 0);
    checkOutput("async mid_tick", int'(mid_tick), 0);
    checkOutput("async bit_tick", int'(bit_tick), 0);
    checkOutput("async phase", int'(phase), 0);
    checkOutput("async div_cur", int'(div_cur), 27);
    checkOutput("async load_err", int'(load_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
